packer_config_sequencer: RTL and testbench
==========================================

Name: packer_config_sequencer

Overview:
- Sequences the reconfiguration of packer/filter instrumentation blocks, which reconfigure only while `tracing` is low.
- Each block counts consecutive cycles in which `configId` equals its personal ID and latches `configData` byte-by-byte. A gap cycle with a non-matching ID resets that count.
- This block buffers one host-supplied firmware image, quiesces tracing, drains the pipeline, streams the image back-to-back to one target ID with guard gaps, then restores tracing.
- It sits between the host/config port and the shared `tracing`/`configId`/`configData` bus.

Parameters:
- MAX_BYTES, 16, capacity of the firmware image buffer in bytes (covers 2*MAX_CHAINS of 8).
- IDLE_ID, 8'hFF, `configId` value driven whenever no block is addressed; never a valid target.
- DRAIN_CYCLES, 4, consecutive cycles with `pipe_busy` low required before streaming.
- CW, $clog2(MAX_BYTES+1), width of byte counts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tracing_req  in  1  host-requested tracing state when not reconfiguring
- start  in  1  one-cycle request to load and send an image
- target_id  in  8  PERSONAL_CONFIG_ID of destination block; sampled with `start`
- byte_count  in  CW  image length; sampled with `start`
- s_data  in  8  image byte stream
- s_valid  in  1  `s_data` valid
- s_ready  out  1  sequencer accepts a byte
- pipe_busy  in  1  OR of valid flags in the instrumentation pipeline
- tracing  out  1  tracing enable to all blocks
- configId  out  8  config address bus
- configData  out  8  config data bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on return to IDLE after a completed image
- error  out  1  one-cycle pulse on a rejected start

Behaviour:
- All outputs are registered.
- Reset values:
  - `tracing`=0, `configId`=IDLE_ID, `configData`=0.
  - `s_ready`=0, `busy`=0, `done`=0, `error`=0.
  - State=IDLE, counters=0.
- States: IDLE, LOAD, DRAIN, GAP_PRE, STREAM, GAP_POST.
- IDLE:
  - `tracing` follows `tracing_req` with 1-cycle latency; `configId`=IDLE_ID.
  - On `start`:
    - If `byte_count`==0, `byte_count`>MAX_BYTES, or `target_id`==IDLE_ID: pulse `error` next cycle and stay IDLE.
    - Otherwise latch `target_id`/`byte_count`, clear the write index, go to LOAD.
  - `start` in any non-IDLE state is ignored; no error.
- LOAD:
  - `s_ready`=1; a byte is accepted when `s_valid`&`s_ready`, written to buf[wr_idx], and wr_idx increments.
  - `tracing` still follows `tracing_req`; loading is non-disruptive.
  - After the byte_count-th accept, `s_ready` drops the next cycle and state goes to DRAIN. No extra byte is accepted.
- DRAIN:
  - `tracing`=0 from the first DRAIN cycle.
  - A drain counter increments each cycle `pipe_busy`=0 and clears on any cycle `pipe_busy`=1.
  - When the counter reaches DRAIN_CYCLES, go to GAP_PRE.
  - A permanently busy pipe stalls here indefinitely; no timeout.
- GAP_PRE: exactly 1 cycle, `configId`=IDLE_ID, `configData`=0. Guarantees the target's byte counter is reset.
- STREAM:
  - Exactly byte_count consecutive cycles; cycle k drives `configId`=target_id and `configData`=buf[k], k=0..byte_count-1.
  - No bubbles are permitted; the image is fully buffered.
  - `tracing` stays 0.
- GAP_POST: 1 cycle, `configId`=IDLE_ID, `configData`=0, `tracing`=0.
- Return to IDLE:
  - `done`=1 in the first IDLE cycle.
  - `tracing` takes the current `tracing_req` in that same cycle.
- `busy`=1 in LOAD through GAP_POST.
- `error` and `done` are never asserted together.
- Buffer contents are undefined outside LOAD/STREAM.
- A new image fully overwrites indices 0..byte_count-1; there is no stale-byte dependence.
- Reset mid-operation, any state: all outputs return to reset values the next cycle. In particular `configId`=IDLE_ID, so partially written target counters reset; the partial image is discarded and no `done` is issued.
- `tracing_req` changes during DRAIN..GAP_POST are ignored until IDLE.
- Reference timeline (start at cycle 0, byte_count=2, bytes at cycles 1 and 2, DRAIN_CYCLES=4, `pipe_busy`=0):

| Cycles | State | Key outputs |
|---|---|---|
| 1-2 | LOAD | `s_ready`=1 |
| 3-6 | DRAIN | `tracing`=0 from cycle 3 |
| 7 | GAP_PRE | `configId`=IDLE_ID |
| 8-9 | STREAM | `configId`=target_id |
| 10 | GAP_POST | `configId`=IDLE_ID |
| 11 | IDLE | `done`=1, `tracing`=`tracing_req` |

Test Plan:
- Basic image: `tracing_req`=1, start id=3, count=2, bytes 0xA1,0xB2 with `s_valid` constant.
  - Required: timeline above exactly; `configId`=3 only at cycles 8-9 with data 0xA1,0xB2; `done` only at cycle 11; `tracing`=1 again at cycle 11.
- Drain hold-off: as the basic image, but `pipe_busy`=1 at cycles 3-5 and again at cycle 8 of DRAIN.
  - Required: the counter restarts each time; STREAM starts only after 4 consecutive idle cycles; `tracing` stays 0 throughout.
- Gapped load: count=8 with `s_valid` toggling every other cycle.
  - Required: exactly 8 accepts; `s_ready` low after the 8th; STREAM emits all 8 bytes in order in 8 consecutive cycles.
- Rejections:
  - start with count=0, then count=MAX_BYTES+1, then id=0xFF: `error` pulses after each, `busy` stays 0, `configId` stays 0xFF.
  - start while `busy`: ignored, no error.
- Reset mid-STREAM: assert `rst` at the 2nd STREAM cycle of a count=4 image.
  - Required: next cycle `configId`=0xFF, `tracing`=0, `busy`=0, `done` never pulses.
  - A following full image completes normally.
- Back-to-back images: targets 1 then 2, with start issued in the `done` cycle.
  - Required: a GAP cycle with `configId`=0xFF precedes and follows each STREAM burst; no cycle drives id 1 and id 2 adjacent.

Source files
------------

// File: rtl/packer_config_sequencer.sv
// Buffers one firmware image, quiesces tracing, drains the instrumentation pipe,
// then streams the image to one config ID framed by idle-ID guard cycles.
module packer_config_sequencer #(
  parameter int         MAX_BYTES    = 16,
  parameter logic [7:0] IDLE_ID      = 8'hFF,
  parameter int         DRAIN_CYCLES = 4,
  parameter int         CW           = $clog2(MAX_BYTES+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tracing_req,
  input  logic          start,
  input  logic [7:0]    target_id,
  input  logic [CW-1:0] byte_count,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          pipe_busy,
  output logic          tracing,
  output logic [7:0]    configId,
  output logic [7:0]    configData,
  output logic          busy,
  output logic          done,
  output logic          error
);
  localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES+1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, GAP_PRE, STREAM, GAP_POST} state_t;

  state_t                      state, next_state;
  logic [7:0]                  tid_q;
  logic [CW-1:0]               cnt_q, idx_q;
  logic [DW-1:0]               dcnt_q;
  logic [MAX_BYTES-1:0][7:0]   buf_q;

  logic       accept, bad_start;
  logic       s_ready_d, tracing_d, busy_d, done_d, error_d;
  logic [7:0] id_d, data_d;

  assign accept    = s_valid & s_ready;
  assign bad_start = start && (byte_count == '0 || byte_count > CW'(MAX_BYTES) ||
                               target_id == IDLE_ID);

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tid_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      dcnt_q     <= '0;
      s_ready    <= 1'b0;
      tracing    <= 1'b0;
      configId   <= IDLE_ID;
      configData <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= next_state;
      s_ready    <= s_ready_d;
      tracing    <= tracing_d;
      configId   <= id_d;
      configData <= data_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      case (state)
        IDLE: begin
          idx_q  <= '0;
          dcnt_q <= '0;
          if (start && !bad_start) begin
            tid_q <= target_id;
            cnt_q <= byte_count;
          end
        end
        LOAD: begin
          dcnt_q <= '0;
          if (accept) idx_q <= idx_q + CW'(1);
        end
        DRAIN: begin
          idx_q  <= '0;
          dcnt_q <= pipe_busy ? '0 : dcnt_q + DW'(1);
        end
        GAP_PRE, STREAM: if (next_state == STREAM) idx_q <= idx_q + CW'(1);
        default: ;
      endcase
    end
  end

  // Image buffer carries no reset; every image rewrites the bytes it uses
  always_ff @(posedge clk) begin
    if (state == LOAD && accept) buf_q[idx_q[AW-1:0]] <= s_data;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start && !bad_start) next_state = LOAD;
      LOAD:     if (accept && idx_q == cnt_q - CW'(1)) next_state = DRAIN;
      DRAIN:    if (!pipe_busy && dcnt_q == DW'(DRAIN_CYCLES-1)) next_state = GAP_PRE;
      GAP_PRE:  next_state = STREAM;
      STREAM:   if (idx_q == cnt_q) next_state = GAP_POST;
      GAP_POST: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they line up with it
  always_comb begin
    s_ready_d = (next_state == LOAD);
    busy_d    = (next_state != IDLE);
    tracing_d = (next_state == IDLE || next_state == LOAD) ? tracing_req : 1'b0;
    id_d      = IDLE_ID;
    data_d    = '0;
    if (next_state == STREAM) begin
      id_d   = tid_q;
      data_d = buf_q[idx_q[AW-1:0]];
    end
    done_d  = (state == GAP_POST);
    error_d = (state == IDLE) && bad_start;
  end
endmodule

// File: tb/tb_packer_config_sequencer.sv
// Directed bench: cycle table for the basic image, then multi-cycle scenarios.
module tb_packer_config_sequencer;
  localparam int CW = 5;

  logic          clk = 1'b0, rst, tracing_req, start, s_valid, s_ready, pipe_busy;
  logic [7:0]    target_id, s_data, configId, configData;
  logic [CW-1:0] byte_count;
  logic          tracing, busy, done, error;

  always #5 clk = ~clk;

  packer_config_sequencer dut (
    .clk(clk), .rst(rst), .tracing_req(tracing_req), .start(start),
    .target_id(target_id), .byte_count(byte_count), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .pipe_busy(pipe_busy),
    .tracing(tracing), .configId(configId), .configData(configData),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct packed {
    logic       s_ready;
    logic       tracing;
    logic [7:0] cid;
    logic [7:0] cdata;
    logic       busy;
    logic       done;
    logic       error;
  } outs_t;

  typedef struct {
    logic          start;
    logic [7:0]    tid;
    logic [CW-1:0] cnt;
    logic          sv;
    logic [7:0]    sd;
    logic          pb;
    logic          trq;
    outs_t         exp;
  } vec_t;

  int total = 0, bad = 0;
  logic [7:0] img [16];
  logic [7:0] got [16];
  int   r_tstream, r_tdone, r_nstream, r_extra, r_err;
  logic r_trbad, r_gapbad, r_sr_after;
  outs_t r_rst_outs;
  logic  adj_bad = 1'b0, de_bad = 1'b0;
  logic [7:0] mon_prev = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic outs_t cur_outs();
    outs_t o;
    o.s_ready = s_ready; o.tracing = tracing; o.cid = configId; o.cdata = configData;
    o.busy = busy; o.done = done; o.error = error;
    return o;
  endfunction

  function automatic vec_t mkv(input logic st, input logic [7:0] tid, input logic [CW-1:0] cnt,
                               input logic sv, input logic [7:0] sd, input logic pb,
                               input logic sr, input logic tr, input logic [7:0] cid,
                               input logic [7:0] cd, input logic bz, input logic dn);
    vec_t v;
    v.start = st; v.tid = tid; v.cnt = cnt; v.sv = sv; v.sd = sd; v.pb = pb; v.trq = 1'b1;
    v.exp.s_ready = sr; v.exp.tracing = tr; v.exp.cid = cid; v.exp.cdata = cd;
    v.exp.busy = bz; v.exp.done = dn; v.exp.error = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Global bus properties: no two different targets on adjacent cycles, done/error exclusive
  always @(negedge clk) begin
    if (!rst) begin
      if ((mon_prev == 8'd1 || mon_prev == 8'd2) && (configId == 8'd1 || configId == 8'd2) &&
          configId != mon_prev) adj_bad = 1'b1;
      if (done && error) de_bad = 1'b1;
    end
    mon_prev = configId;
  end

  // Cycle 0 is the start cycle; observe first, then drive, then advance.
  // Returns in the done cycle without advancing so a follow-on start lands there.
  task automatic run_image(input logic [7:0] tid, input int n, input bit gapped,
                           input logic [31:0] bmask, input int abort_k, input bit restart);
    int delivered = 0, last_acc = -1, stop_c = -1;
    logic [7:0] prev_id;
    r_tstream = -1; r_tdone = -1; r_nstream = 0; r_extra = 0; r_err = 0;
    r_trbad = 1'b0; r_gapbad = 1'b0; r_sr_after = 1'b1; r_rst_outs = '0;
    prev_id = configId;
    for (int c = 0; c < 300; c++) begin
      if (c > 0 && done) r_tdone = c;
      if (error) r_err++;
      if (configId == tid) begin
        if (r_tstream < 0) r_tstream = c;
        if (r_nstream < 16) got[r_nstream] = configData;
        r_nstream++;
      end
      if ((configId == tid && prev_id != tid && prev_id != 8'hFF) ||
          (configId != tid && prev_id == tid && configId != 8'hFF)) r_gapbad = 1'b1;
      prev_id = configId;
      if (last_acc >= 0 && c == last_acc + 1) r_sr_after = s_ready;
      if (delivered == n && c > last_acc && r_tdone < 0 && tracing) r_trbad = 1'b1;
      if (r_tdone >= 0) break;
      if (stop_c >= 0 && c >= stop_c) break;
      start      = (c == 0) || (restart && c == 3);
      target_id  = (c == 0) ? tid : 8'h07;
      byte_count = (c == 0) ? CW'(n) : CW'(1);
      pipe_busy  = (c < 32) ? bmask[c] : 1'b0;
      s_valid    = gapped ? (c % 2 == 1) : 1'b1;
      s_data     = (delivered < n) ? img[delivered] : 8'hEE;
      if (abort_k > 0 && r_nstream == abort_k && stop_c < 0) begin
        rst = 1'b1;
        stop_c = c + 20;
      end
      if (s_valid && s_ready) begin
        if (delivered < n) begin delivered++; last_acc = c; end
        else r_extra++;
      end
      tick();
      if (rst) begin
        r_rst_outs = cur_outs();
        rst = 1'b0;
      end
    end
    start = 1'b0;
    pipe_busy = 1'b0;
  endtask

  task automatic reject(input string name, input logic [7:0] tid, input logic [CW-1:0] cnt);
    start = 1'b1; target_id = tid; byte_count = cnt;
    tick();
    start = 1'b0;
    check({name, " error"}, error, 1);
    check({name, " busy"}, busy, 0);
    check({name, " id"}, configId, 8'hFF);
    tick();
    check({name, " error clr"}, error, 0);
  endtask

  vec_t tv [13];

  initial begin
    rst = 1'b1; tracing_req = 1'b1; start = 1'b0; target_id = '0; byte_count = '0;
    s_data = '0; s_valid = 1'b0; pipe_busy = 1'b0;
    tick(); tick();
    check("reset outs", cur_outs(), {1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    tick();

    // Basic image, reference timeline
    tv[0]  = mkv(1, 8'd3, 5'd2, 1, 8'hEE, 0,  0, 1, 8'hFF, 8'h00, 0, 0);
    tv[1]  = mkv(0, 8'd0, 5'd0, 1, 8'hA1, 0,  1, 1, 8'hFF, 8'h00, 1, 0);
    tv[2]  = mkv(0, 8'd0, 5'd0, 1, 8'hB2, 0,  1, 1, 8'hFF, 8'h00, 1, 0);
    for (int i = 3; i <= 7; i++)
      tv[i] = mkv(0, 8'd0, 5'd0, 1, 8'hEE, 0, 0, 0, 8'hFF, 8'h00, 1, 0);
    tv[8]  = mkv(0, 8'd0, 5'd0, 1, 8'hEE, 0,  0, 0, 8'h03, 8'hA1, 1, 0);
    tv[9]  = mkv(0, 8'd0, 5'd0, 1, 8'hEE, 0,  0, 0, 8'h03, 8'hB2, 1, 0);
    tv[10] = mkv(0, 8'd0, 5'd0, 1, 8'hEE, 0,  0, 0, 8'hFF, 8'h00, 1, 0);
    tv[11] = mkv(0, 8'd0, 5'd0, 1, 8'hEE, 0,  0, 1, 8'hFF, 8'h00, 0, 1);
    tv[12] = mkv(0, 8'd0, 5'd0, 1, 8'hEE, 0,  0, 1, 8'hFF, 8'h00, 0, 0);
    for (int i = 0; i < 13; i++) begin
      start = tv[i].start; target_id = tv[i].tid; byte_count = tv[i].cnt;
      s_valid = tv[i].sv; s_data = tv[i].sd; pipe_busy = tv[i].pb; tracing_req = tv[i].trq;
      check($sformatf("vec%0d", i), cur_outs(), tv[i].exp);
      tick();
    end
    s_valid = 1'b0;

    // Drain hold-off: pipe busy at cycles 3-5 and 8
    img[0] = 8'hA1; img[1] = 8'hB2;
    run_image(8'd3, 2, 0, 32'h0000_0138, 0, 0);
    check("holdoff stream", r_tstream, 14);
    check("holdoff done", r_tdone, 17);
    check("holdoff tracing", r_trbad, 0);
    check("holdoff bytes", {got[0], got[1]}, 16'hA1B2);

    // Gapped load of 8 bytes
    for (int k = 0; k < 8; k++) img[k] = 8'h40 + 8'(k * 7);
    run_image(8'd9, 8, 1, 32'h0, 0, 0);
    check("gapped extra", r_extra, 0);
    check("gapped sready", r_sr_after, 0);
    check("gapped stream", r_tstream, 21);
    check("gapped count", r_nstream, 8);
    check("gapped done", r_tdone, 30);
    check("gapped framing", r_gapbad, 0);
    for (int k = 0; k < 8; k++) check($sformatf("gapped byte%0d", k), got[k], img[k]);
    tick();

    // Rejections and ignored start while busy
    reject("cnt0", 8'd3, 5'd0);
    reject("cnt17", 8'd3, 5'd17);
    reject("idle id", 8'hFF, 5'd2);
    img[0] = 8'h11; img[1] = 8'h22;
    run_image(8'd4, 2, 0, 32'h0, 0, 1);
    check("restart err", r_err, 0);
    check("restart done", r_tdone, 11);
    check("restart bytes", {got[0], got[1]}, 16'h1122);
    tick();

    // Reset in the 2nd STREAM cycle, then a full image
    for (int k = 0; k < 4; k++) img[k] = 8'hC0 + 8'(k);
    run_image(8'd5, 4, 0, 32'h0, 2, 0);
    check("rst outs", r_rst_outs, {1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0});
    check("rst no done", r_tdone, 32'hFFFF_FFFF);
    check("rst partial", r_nstream, 2);
    img[0] = 8'h5A; img[1] = 8'h6B; img[2] = 8'h7C;
    run_image(8'd6, 3, 0, 32'h0, 0, 0);
    check("post rst stream", r_tstream, 9);
    check("post rst done", r_tdone, 13);
    check("post rst bytes", {got[0], got[1], got[2]}, 24'h5A6B7C);
    tick();

    // Back-to-back: second start in the done cycle of the first
    img[0] = 8'h01; img[1] = 8'h02;
    run_image(8'd1, 2, 0, 32'h0, 0, 0);
    check("b2b1 done", r_tdone, 11);
    check("b2b1 framing", r_gapbad, 0);
    img[0] = 8'h03; img[1] = 8'h04;
    run_image(8'd2, 2, 0, 32'h0, 0, 0);
    check("b2b2 stream", r_tstream, 8);
    check("b2b2 done", r_tdone, 11);
    check("b2b2 framing", r_gapbad, 0);
    check("b2b2 bytes", {got[0], got[1]}, 16'h0304);
    tick(); tick();
    check("adjacent ids", adj_bad, 0);
    check("done error excl", de_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
